// File: rtl/axis_timer_seq_pkg.sv
// axis_timer_seq_pkg: shared types and constants for the countdown-timer sequencer.
package axis_timer_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int LOOP_WIDTH = 16;

endpackage

// File: rtl/axis_timer_seq_if.sv
// axis_timer_seq_if: control/status link between the sequencer and the AXI-Stream timer.
// The sequencer side is the master (it drives the cfg/run flags); the timer is the slave.
interface axis_timer_seq_if #(
  parameter int CNTR_WIDTH = 64
);

  logic                  tmr_cfg_flag;
  logic [CNTR_WIDTH-1:0] tmr_cfg_data;
  logic                  tmr_run_flag;
  logic                  tmr_trg_flag;

  modport master (
    output tmr_cfg_flag,
    output tmr_cfg_data,
    output tmr_run_flag,
    input  tmr_trg_flag
  );

  modport slave (
    input  tmr_cfg_flag,
    input  tmr_cfg_data,
    input  tmr_run_flag,
    output tmr_trg_flag
  );

endinterface

// File: rtl/axis_timer_seq_mux.sv
// axis_timer_seq_mux: combinational STEPS:1 selector picking one interval out of the
// packed interval table. The parent registers the result onto the timer cfg_data.
module axis_timer_seq_mux
  import axis_timer_seq_pkg::*;
#(
  parameter int CNTR_WIDTH = 64,
  parameter int STEPS      = 4,
  parameter int IDX_WIDTH  = 2
) (
  input  logic [STEPS*CNTR_WIDTH-1:0] cfg_intervals,
  input  logic [IDX_WIDTH-1:0]        idx,
  output logic [CNTR_WIDTH-1:0]       interval
);

  // Pick the table entry whose index matches; unused index codes give zero.
  always_comb begin
    interval = '0;
    for (int i = 0; i < STEPS; i++) begin
      if (idx == IDX_WIDTH'(i)) begin
        interval = cfg_intervals[i*CNTR_WIDTH +: CNTR_WIDTH];
      end
    end
  end

endmodule

// File: rtl/axis_timer_seq.sv
// axis_timer_seq: plays a table of up to STEPS countdown intervals back to back on the
// AXI-Stream timer. Each step loads the timer, runs it until trg_flag drops, then
// pulses step_strobe; done pulses after the last step of the sequence.
// Optional feature macro TIMER_SEQ_LOOP_EN: adds cfg_loops and repeats the whole
// table cfg_loops times (0 = until abort) without passing through IDLE.
module axis_timer_seq
  import axis_timer_seq_pkg::*;
#(
  parameter int CNTR_WIDTH = 64,
  parameter int STEPS      = 4,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        start,
  input  logic                        abort,
  input  logic [IDX_WIDTH:0]          cfg_steps,
  input  logic [STEPS*CNTR_WIDTH-1:0] cfg_intervals,
`ifdef TIMER_SEQ_LOOP_EN
  input  logic [LOOP_WIDTH-1:0]       cfg_loops,
`endif
  axis_timer_seq_if.master            tmr,
  output logic [IDX_WIDTH-1:0]        step_idx,
  output logic                        step_strobe,
  output logic                        busy,
  output logic                        done
);

  localparam logic [IDX_WIDTH:0] STEPS_MAX = (IDX_WIDTH+1)'(STEPS);

  state_t                  state, state_next;
  logic [IDX_WIDTH-1:0]    idx, idx_next;
  logic [IDX_WIDTH:0]      steps_reg, steps_next;
  logic                    strobe_next, done_next;
  logic [CNTR_WIDTH-1:0]   interval_next, cfg_data;
  logic                    cfg_ok, last_step, more_passes;
`ifdef TIMER_SEQ_LOOP_EN
  logic [LOOP_WIDTH-1:0]   loops_reg, loops_next, pass_cnt, pass_next;
`endif

  assign cfg_ok    = (cfg_steps != '0) && (cfg_steps <= STEPS_MAX);
  assign last_step = ({1'b0, idx} == (steps_reg - (IDX_WIDTH+1)'(1)));

`ifdef TIMER_SEQ_LOOP_EN
  assign more_passes = (loops_reg == '0) || (pass_cnt != (loops_reg - LOOP_WIDTH'(1)));
`else
  assign more_passes = 1'b0;
`endif

  // Interval for the step about to be loaded, selected from the live table.
  axis_timer_seq_mux #(
    .CNTR_WIDTH (CNTR_WIDTH),
    .STEPS      (STEPS),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_mux (
    .cfg_intervals (cfg_intervals),
    .idx           (idx_next),
    .interval      (interval_next)
  );

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus next values of the step index, latched config and pulses.
  always_comb begin
    state_next  = state;
    idx_next    = idx;
    steps_next  = steps_reg;
    strobe_next = 1'b0;
    done_next   = 1'b0;
`ifdef TIMER_SEQ_LOOP_EN
    loops_next  = loops_reg;
    pass_next   = pass_cnt;
`endif
    case (state)
      IDLE: begin
        if (start && cfg_ok) begin
          state_next = LOAD;
          idx_next   = '0;
          steps_next = cfg_steps;
`ifdef TIMER_SEQ_LOOP_EN
          loops_next = cfg_loops;
          pass_next  = '0;
`endif
        end
      end
      LOAD: begin
        state_next = RUN;
      end
      RUN: begin
        if (!tmr.tmr_trg_flag) begin
          strobe_next = 1'b1;
          if (!last_step) begin
            idx_next   = idx + IDX_WIDTH'(1);
            state_next = LOAD;
          end else begin
            idx_next = '0;
            if (more_passes) begin
`ifdef TIMER_SEQ_LOOP_EN
              pass_next = pass_cnt + LOOP_WIDTH'(1);
`endif
              state_next = LOAD;
            end else begin
              done_next  = 1'b1;
              state_next = IDLE;
            end
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
    if (abort) begin
      state_next  = IDLE;
      idx_next    = '0;
      strobe_next = 1'b0;
      done_next   = 1'b0;
    end
  end

  // Registered datapath: index, latched config, pulses and the timer load value.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      idx         <= '0;
      steps_reg   <= '0;
      step_strobe <= 1'b0;
      done        <= 1'b0;
      cfg_data    <= '0;
`ifdef TIMER_SEQ_LOOP_EN
      loops_reg   <= '0;
      pass_cnt    <= '0;
`endif
    end else begin
      idx         <= idx_next;
      steps_reg   <= steps_next;
      step_strobe <= strobe_next;
      done        <= done_next;
      cfg_data    <= (state_next == LOAD) ? interval_next : '0;
`ifdef TIMER_SEQ_LOOP_EN
      loops_reg   <= loops_next;
      pass_cnt    <= pass_next;
`endif
    end
  end

  assign busy             = (state != IDLE);
  assign step_idx         = idx;
  assign tmr.tmr_cfg_flag = (state == LOAD);
  assign tmr.tmr_run_flag = (state == RUN);
  assign tmr.tmr_cfg_data = cfg_data;

endmodule

// File: tb/tb_axis_timer_seq.sv
// tb_axis_timer_seq: bench for axis_timer_seq with a behavioural countdown timer,
// a cycle-level expectation model and directed literal timelines.
module tb_axis_timer_seq;
  import axis_timer_seq_pkg::*;

  localparam int CW    = 64;
  localparam int STEPS = 4;
  localparam int IW    = 2;

  logic                  aclk = 1'b0;
  logic                  aresetn = 1'b0;
  logic                  start = 1'b0;
  logic                  abort = 1'b0;
  logic [IW:0]           cfg_steps = '0;
  logic [STEPS*CW-1:0]   cfg_intervals = '0;
`ifdef TIMER_SEQ_LOOP_EN
  logic [LOOP_WIDTH-1:0] cfg_loops = 16'd1;
`endif
  logic [IW-1:0]         step_idx;
  logic                  step_strobe, busy, done;

  axis_timer_seq_if #(.CNTR_WIDTH(CW)) tif();

  axis_timer_seq #(
    .CNTR_WIDTH (CW),
    .STEPS      (STEPS),
    .IDX_WIDTH  (IW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .start         (start),
    .abort         (abort),
    .cfg_steps     (cfg_steps),
    .cfg_intervals (cfg_intervals),
`ifdef TIMER_SEQ_LOOP_EN
    .cfg_loops     (cfg_loops),
`endif
    .tmr           (tif),
    .step_idx      (step_idx),
    .step_strobe   (step_strobe),
    .busy          (busy),
    .done          (done)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 1 << 30;

  // Countdown timer stand-in: load on cfg_flag, count down on run & tvalid.
  logic          tvalid = 1'b1;
  bit            throttle = 1'b0;
  logic [CW-1:0] tcnt;
  int            dec_cnt = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  always @(posedge aclk) begin
    #1;
    tvalid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tcnt <= '0;
    end else if (tif.tmr_cfg_flag) begin
      tcnt <= tif.tmr_cfg_data;
    end else if (tif.tmr_run_flag && tvalid && tcnt != '0) begin
      tcnt    <= tcnt - 1;
      dec_cnt <= dec_cnt + 1;
    end
  end

  assign tif.tmr_trg_flag = tif.tmr_run_flag && (tcnt != '0);

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expectation model: sequence position tracked as step/pass counters.
  bit  m_active = 0, m_loading = 0;
  int  m_step = 0, m_pass = 0, m_steps = 0, m_loops = 0;
  bit  e_busy = 0, e_cfg = 0, e_run = 0, e_strobe = 0, e_done = 0;
  int  e_idx = 0;
  logic [CW-1:0] e_data = '0;

  // Per-start observation log, indexed by cycles since the start pulse.
  logic [63:0] obs_busy, obs_cfg, obs_run, obs_strobe, obs_done, obs_trg;
  int          obs_idx [0:63];
  logic [CW-1:0] obs_data [0:63];

  always @(negedge aclk) begin
    int  rel;
    bit  more;
    if (!aresetn) begin
      m_active = 0; m_loading = 0; m_step = 0; m_pass = 0;
      e_busy = 0; e_cfg = 0; e_run = 0; e_strobe = 0; e_done = 0; e_idx = 0; e_data = '0;
    end
    check_output("busy", busy, e_busy);
    check_output("cfg_flag", tif.tmr_cfg_flag, e_cfg);
    check_output("run_flag", tif.tmr_run_flag, e_run);
    check_output("step_idx", step_idx, e_idx);
    check_output("step_strobe", step_strobe, e_strobe);
    check_output("done", done, e_done);
    if (e_cfg) check_output("cfg_data", tif.tmr_cfg_data, e_data);

    rel = cyc - start_cyc;
    if (rel >= 0 && rel < 64) begin
      obs_busy[rel]   = busy;
      obs_cfg[rel]    = tif.tmr_cfg_flag;
      obs_run[rel]    = tif.tmr_run_flag;
      obs_strobe[rel] = step_strobe;
      obs_done[rel]   = done;
      obs_trg[rel]    = tif.tmr_trg_flag;
      obs_idx[rel]    = int'(step_idx);
      obs_data[rel]   = tif.tmr_cfg_data;
    end

    if (aresetn) begin
      e_strobe = 0;
      e_done   = 0;
      if (abort) begin
        m_active = 0; m_step = 0;
      end else if (!m_active) begin
        if (start && int'(cfg_steps) >= 1 && int'(cfg_steps) <= STEPS) begin
          m_active = 1; m_loading = 1; m_step = 0; m_pass = 0; m_steps = int'(cfg_steps);
`ifdef TIMER_SEQ_LOOP_EN
          m_loops = int'(cfg_loops);
`endif
        end
      end else if (m_loading) begin
        m_loading = 0;
      end else if (!tif.tmr_trg_flag) begin
        e_strobe = 1;
        if (m_step + 1 < m_steps) begin
          m_step++; m_loading = 1;
        end else begin
          m_step = 0;
          m_pass++;
`ifdef TIMER_SEQ_LOOP_EN
          more = (m_loops == 0) || (m_pass < m_loops);
`else
          more = 0;
`endif
          if (more) m_loading = 1;
          else begin m_active = 0; e_done = 1; end
        end
      end
      e_busy = m_active;
      e_cfg  = m_active && m_loading;
      e_run  = m_active && !m_loading;
      e_idx  = m_step;
      e_data = e_cfg ? cfg_intervals[m_step*CW +: CW] : '0;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_iv(input int i, input logic [CW-1:0] v);
    cfg_intervals[i*CW +: CW] = v;
  endtask

  // Drive a one-cycle start pulse; that cycle becomes relative cycle 0 of the log.
  task automatic apply_stimulus(input int steps);
    obs_busy = '0; obs_cfg = '0; obs_run = '0; obs_strobe = '0; obs_done = '0; obs_trg = '0;
    for (int i = 0; i < 64; i++) begin obs_idx[i] = 0; obs_data[i] = '0; end
    start = 1'b1;
    cfg_steps = (IW+1)'(steps);
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int n = 0; n < budget && busy; n++) tick();
    check_output({name, "_idle_timeout"}, busy, 1'b0);
    tick();
    tick();
  endtask

  task automatic check_t1(input string p);
    check_output({p, "_load1"}, obs_cfg[1], 1'b1);
    check_output({p, "_load6"}, obs_cfg[6], 1'b1);
    check_output({p, "_loads"}, $countones(obs_cfg), 2);
    check_output({p, "_data1"}, obs_data[1], 3);
    check_output({p, "_data6"}, obs_data[6], 5);
    check_output({p, "_idx6"}, obs_idx[6], 1);
    check_output({p, "_strb6"}, obs_strobe[6], 1'b1);
    check_output({p, "_strb13"}, obs_strobe[13], 1'b1);
    check_output({p, "_strbs"}, $countones(obs_strobe), 2);
    check_output({p, "_done13"}, obs_done[13], 1'b1);
    check_output({p, "_dones"}, $countones(obs_done), 1);
    check_output({p, "_busy12"}, obs_busy[12], 1'b1);
    check_output({p, "_busy13"}, obs_busy[13], 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s, d0;
    aresetn = 1'b0;
    repeat (3) tick();
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_idx", step_idx, 0);
    check_output("rst_cfg_data", tif.tmr_cfg_data, 0);
    aresetn = 1'b1;
    tick();

    // Two steps {3,5}: literal timeline.
    $display("[TB] two-step sequence");
    set_iv(0, 3); set_iv(1, 5);
    apply_stimulus(2);
    wait_idle(40, "t1");
    check_t1("t1");

    // Zero interval: one RUN cycle.
    $display("[TB] zero interval");
    set_iv(0, 0);
    apply_stimulus(1);
    wait_idle(20, "t2");
    check_output("t2_load1", obs_cfg[1], 1'b1);
    check_output("t2_run2", obs_run[2], 1'b1);
    check_output("t2_strb3", obs_strobe[3], 1'b1);
    check_output("t2_done3", obs_done[3], 1'b1);
    check_output("t2_busy3", obs_busy[3], 1'b0);

    // Abort in cycle 4, then replay from step 0.
    $display("[TB] abort");
    set_iv(0, 3); set_iv(1, 5);
    apply_stimulus(2);
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick(); tick();
    check_output("t3_busy4", obs_busy[4], 1'b1);
    check_output("t3_busy5", obs_busy[5], 1'b0);
    check_output("t3_run5", obs_run[5], 1'b0);
    check_output("t3_idx5", obs_idx[5], 0);
    check_output("t3_dones", $countones(obs_done), 0);
    check_output("t3_strbs", $countones(obs_strobe), 0);
    apply_stimulus(2);
    wait_idle(40, "t3r");
    check_t1("t3r");

    // Rejected starts and starts while busy.
    $display("[TB] ignored starts");
    apply_stimulus(0);
    tick(); tick();
    check_output("t4_zero_busy", $countones(obs_busy), 0);
    apply_stimulus(5);
    tick(); tick();
    check_output("t4_big_busy", $countones(obs_busy), 0);
    check_output("t4_big_dones", $countones(obs_done), 0);
    apply_stimulus(2);
    tick(); tick();
    start = 1'b1; cfg_steps = 3'd1;
    tick();
    start = 1'b0; cfg_steps = 3'd4;
    tick(); tick(); tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(40, "t4");
    check_t1("t4");

    // Asynchronous reset mid-sequence.
    $display("[TB] reset mid-sequence");
    apply_stimulus(2);
    tick(); tick(); tick();
    aresetn = 1'b0;
    #1;
    check_output("rst_mid_busy", busy, 1'b0);
    check_output("rst_mid_run", tif.tmr_run_flag, 1'b0);
    check_output("rst_mid_idx", step_idx, 0);
    tick();
    aresetn = 1'b1;
    tick();

`ifdef TIMER_SEQ_LOOP_EN
    $display("[TB] loop x3");
    cfg_loops = 16'd3;
    set_iv(0, 1); set_iv(1, 2);
    apply_stimulus(2);
    wait_idle(80, "t5");
    check_output("t5_strbs", $countones(obs_strobe), 6);
    check_output("t5_dones", $countones(obs_done), 1);
    s = -1;
    for (int r = 0; r < 64; r++) if (obs_strobe[r]) s = r;
    check_output("t5_done_last", obs_done[(s > 0) ? s : 0], 1'b1);
    $display("[TB] loop forever");
    cfg_loops = 16'd0;
    apply_stimulus(2);
    repeat (55) tick();
    check_output("t5f_dones", $countones(obs_done), 0);
    check_output("t5f_many", $countones(obs_strobe) > 6, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle(5, "t5f");
    cfg_loops = 16'd1;
`endif

    // Throttled tvalid: step ends one cycle after the drained counter drops trg.
    $display("[TB] throttled tvalid");
    throttle = 1'b1;
    set_iv(0, 4);
    d0 = dec_cnt;
    apply_stimulus(1);
    wait_idle(60, "t6");
    throttle = 1'b0;
    check_output("t6_decs", dec_cnt - d0, 4);
    check_output("t6_dones", $countones(obs_done), 1);
    s = -1;
    for (int r = 1; r < 64; r++) if (obs_strobe[r] && s < 0) s = r;
    check_output("t6_strobe_seen", s > 1, 1'b1);
    check_output("t6_trg_fall", obs_trg[(s > 1) ? s - 1 : 0], 1'b0);
    check_output("t6_run_before", obs_run[(s > 1) ? s - 1 : 0], 1'b1);

    // Randomized sequences with spurious starts, config churn and rare aborts.
    $display("[TB] random sequences");
    for (int it = 0; it < 30; it++) begin
      throttle = 1'($urandom_range(0, 1));
      for (int i = 0; i < STEPS; i++) set_iv(i, CW'($urandom_range(0, 6)));
`ifdef TIMER_SEQ_LOOP_EN
      cfg_loops = 16'($urandom_range(1, 3));
`endif
      abort = ($urandom_range(0, 9) == 0);
      apply_stimulus($urandom_range(0, 5));
      abort = 1'b0;
      for (int n = 0; n < 150 && (busy || n < 2); n++) begin
        start     = ($urandom_range(0, 7) == 0);
        cfg_steps = (IW+1)'($urandom_range(0, 7));
        abort     = ($urandom_range(0, 49) == 0);
        tick();
      end
      start = 1'b0;
      abort = 1'b0;
      wait_idle(250, "rand");
    end
    throttle = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
